seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
Receive-side counterpart of the hex-to-7-segment decode path. Samples a multiplexed 7-segment bus (segment lines plus one-hot digit select) and reconstructs the per-digit hex nibble and decimal-point state. Used for display loopback checking and self-test: the display driver output is fed back in and compared against the intended values.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
STABLE_CYCLES, 4, consecutive identical registered samples required before a capture; legal range 2..255.

Ports:
clk  input  1  system clock; all logic rising-edge.
rst_n  input  1  reset, asynchronous assert, active-low.
seg_in  input  8  segment lines, active-high; bit7..0 = A,B,C,D,E,F,G,DP. Synchronous to clk.
dig_sel  input  NUM_DIGITS  digit enable, active-high, expected one-hot; bit i = digit i.
hex_out  output  4*NUM_DIGITS  captured nibble per digit; digit i at [4i+3:4i].
dp_out  output  NUM_DIGITS  captured DP per digit.
digit_valid  output  NUM_DIGITS  bit i set = hex_out slot i holds a decoded hex glyph.
frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.
pattern_err  output  1  one-cycle pulse when a stable pattern matches no glyph.
err_count  output  8  error counter; see Optional Feature.

Behaviour:
- Reset: asynchronous and active-low on rst_n. While reset is asserted, every register and output is 0: hex_out, dp_out, digit_valid, frame_done, pattern_err, err_count, the seen mask, the stability counter and the input register.
- Input stage: {dig_sel, seg_in} is registered once. All logic below operates on the registered copy.
- Stability counter, width 8, saturating at STABLE_CYCLES:
  - Registered dig_sel not one-hot (zero or multi-hot): counter is set to 0. No capture occurs. This is treated as blanking between digits.
  - One-hot and the registered sample equals the previous registered sample: counter increments, saturating.
  - One-hot and the sample changed: counter is set to 1.
- Capture event: occurs in the cycle the counter transitions to STABLE_CYCLES. There is exactly one capture per stable dwell; a long dwell is not recaptured. With new inputs held constant, outputs update at the (STABLE_CYCLES+1)-th rising edge at which those inputs are present.
- Decode at capture, for digit i = index of the set dig_sel bit. seg[7:1] is compared against the 16 glyphs (hex 0..F):
  0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Match: hex_out[i] <= matched value; dp_out[i] <= seg[0]; digit_valid[i] <= 1; seen[i] <= 1.
  - seg[7:1] == 0 (blank digit): digit_valid[i] <= 0; dp_out[i] <= seg[0]; hex_out[i] unchanged; seen[i] <= 1; no error.
  - Otherwise: digit_valid[i] <= 0; hex_out[i] and dp_out[i] unchanged; seen[i] unchanged; pattern_err pulses for 1 cycle, registered, coincident with the update of the other outputs.
- Frame: when seen (including the bit being set this cycle) is all ones, frame_done pulses for 1 cycle and seen clears to 0 in the same cycle. A capture for digit i while seen[i] is already 1 overwrites that slot; seen[i] stays 1.
- Outputs other than the pulses hold their value between captures.
- Reset mid-capture: all state is lost. After rst_n deasserts, a fresh STABLE_CYCLES dwell is required before any capture.

Optional Feature:
Macro SEG_CAPTURE_ERR_COUNT_EN.
- Defined: err_count is an 8-bit counter that increments on each pattern_err pulse and saturates at 255. It is cleared only by reset.
- Undefined: err_count is tied to 0 and no counter register is built. The port list is identical in both builds.

Test Plan:
- Reset, then hold dig_sel=0001, seg_in=11011010 for 8 cycles -> hex_out[3:0]=2, digit_valid=0001, dp_out=0000. The update occurs at edge 5 (STABLE_CYCLES=4).
- Scan digits 0..3 with 11100001 / 01100000 / 10011100 / 11111110 for 6 cycles each, with 1 blank cycle (dig_sel=0) between -> hex_out=16'h8C17, dp_out=0001, digit_valid=1111; frame_done pulses once, on digit 3's capture cycle.
- Hold dig_sel=0010, seg_in=00001110 for 6 cycles -> pattern_err pulses once, digit_valid[1]=0, hex_out[7:4] unchanged; with SEG_CAPTURE_ERR_COUNT_EN, err_count goes 0 to 1.
- Toggle seg_in every 3 cycles between two valid glyphs on digit 0 -> no capture; outputs unchanged; no pulses.
- dig_sel=0011 held 10 cycles with a valid glyph -> no capture; all outputs unchanged.
- Assert rst_n low at the 3rd stable cycle of a dwell, release, keep inputs constant -> all outputs 0 during reset; capture occurs 5 edges after release.

Source files
------------

// File: rtl/seg_scan_capture.sv
// Multiplexed 7-segment bus capture: debounces each digit dwell, decodes the glyph
// and rebuilds per-digit hex/DP state. Optional error counter: SEG_CAPTURE_ERR_COUNT_EN.
module seg_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   hex_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_done,
    output logic                      pattern_err,
    output logic [7:0]                err_count
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   sel_q;
    logic [NUM_DIGITS-1:0]   sel_prev;
    logic [7:0]              seg_q;
    logic [7:0]              seg_prev;
    logic [7:0]              stab_cnt;
    logic [7:0]              stab_cnt_next;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   seen_after;
    logic [NUM_DIGITS-1:0]   seen_next;
    logic                    sel_onehot;
    logic                    same_sample;
    logic                    capture;
    logic                    glyph_hit;
    logic [3:0]              glyph_val;
    logic                    glyph_blank;
    logic [4*NUM_DIGITS-1:0] hex_next;
    logic [NUM_DIGITS-1:0]   dp_next;
    logic [NUM_DIGITS-1:0]   valid_next;
    logic                    frame_next;
    logic                    perr_next;

    // Returns {hit, value} for the seven segment lines A..G.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'b1111110: res = {1'b1, 4'h0};
            7'b0110000: res = {1'b1, 4'h1};
            7'b1101101: res = {1'b1, 4'h2};
            7'b1111001: res = {1'b1, 4'h3};
            7'b0110011: res = {1'b1, 4'h4};
            7'b1011011: res = {1'b1, 4'h5};
            7'b1011111: res = {1'b1, 4'h6};
            7'b1110000: res = {1'b1, 4'h7};
            7'b1111111: res = {1'b1, 4'h8};
            7'b1111011: res = {1'b1, 4'h9};
            7'b1110111: res = {1'b1, 4'hA};
            7'b0011111: res = {1'b1, 4'hB};
            7'b1001110: res = {1'b1, 4'hC};
            7'b0111101: res = {1'b1, 4'hD};
            7'b1001111: res = {1'b1, 4'hE};
            7'b1000111: res = {1'b1, 4'hF};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // Input register plus one-sample history used for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            seg_q    <= '0;
            sel_prev <= '0;
            seg_prev <= '0;
        end else begin
            sel_q    <= dig_sel;
            seg_q    <= seg_in;
            sel_prev <= sel_q;
            seg_prev <= seg_q;
        end
    end

    always_comb begin
        sel_onehot  = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
        same_sample = (sel_q == sel_prev) && (seg_q == seg_prev);
    end

    // Blanking (zero or multi-hot select) restarts the dwell from scratch.
    always_comb begin
        stab_cnt_next = stab_cnt;
        if (!sel_onehot) begin
            stab_cnt_next = 8'd0;
        end else if (same_sample) begin
            if (stab_cnt != STABLE_MAX) begin
                stab_cnt_next = stab_cnt + 8'd1;
            end
        end else begin
            stab_cnt_next = 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else begin
            stab_cnt <= stab_cnt_next;
        end
    end

    // Only the transition into saturation captures, so a long dwell fires once.
    assign capture = (stab_cnt_next == STABLE_MAX) && (stab_cnt != STABLE_MAX);

    always_comb begin
        {glyph_hit, glyph_val} = decode_glyph(seg_q[7:1]);
        glyph_blank            = (seg_q[7:1] == 7'd0);
    end

    always_comb begin
        hex_next   = hex_out;
        dp_next    = dp_out;
        valid_next = digit_valid;
        seen_after = seen;
        perr_next  = 1'b0;
        frame_next = 1'b0;
        if (capture) begin
            if (glyph_hit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (sel_q[i]) begin
                        hex_next[4*i +: 4] = glyph_val;
                    end
                end
                dp_next    = (dp_out & ~sel_q) | (seg_q[0] ? sel_q : '0);
                valid_next = digit_valid | sel_q;
                seen_after = seen | sel_q;
            end else if (glyph_blank) begin
                dp_next    = (dp_out & ~sel_q) | (seg_q[0] ? sel_q : '0);
                valid_next = digit_valid & ~sel_q;
                seen_after = seen | sel_q;
            end else begin
                valid_next = digit_valid & ~sel_q;
                perr_next  = 1'b1;
            end
            frame_next = (glyph_hit || glyph_blank) && (&seen_after);
        end
        seen_next = frame_next ? '0 : seen_after;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out     <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            hex_out     <= hex_next;
            dp_out      <= dp_next;
            digit_valid <= valid_next;
            seen        <= seen_next;
            frame_done  <= frame_next;
            pattern_err <= perr_next;
        end
    end

`ifdef SEG_CAPTURE_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Counts in step with the registered pattern_err pulse; saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (perr_next && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: a run-length reference model predicts the
// outputs after every clock edge; a negedge monitor pops and compares them.
module tb_seg_scan_capture;

    localparam int ND = 4;
    localparam int SC = 4;

    typedef struct packed {
        logic [4*ND-1:0] hex;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   valid;
        logic            frame;
        logic            perr;
        logic [7:0]      errc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [7:0]        seg_in;
    logic [ND-1:0]     dig_sel;
    logic [4*ND-1:0]   hex_out;
    logic [ND-1:0]     dp_out;
    logic [ND-1:0]     digit_valid;
    logic              frame_done;
    logic              pattern_err;
    logic [7:0]        err_count;

    exp_t              exp_q[$];
    logic [ND+7:0]     hist[$];
    logic [6:0]        glyph_tbl[16];

    logic [4*ND-1:0]   m_hex;
    logic [ND-1:0]     m_dp;
    logic [ND-1:0]     m_valid;
    logic [ND-1:0]     m_seen;
    logic [7:0]        m_errc;

    int checks;
    int failures;

    seg_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .hex_out     (hex_out),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .err_count   (err_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("hex_out",     32'(hex_out),     32'(e.hex));
            check("dp_out",      32'(dp_out),      32'(e.dp));
            check("digit_valid", 32'(digit_valid), 32'(e.valid));
            check("frame_done",  32'(frame_done),  32'(e.frame));
            check("pattern_err", 32'(pattern_err), 32'(e.perr));
            check("err_count",   32'(err_count),   32'(e.errc));
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [ND+7:0] hist_at(input int k);
        if (k < 1 || k > hist.size()) return '0;
        return hist[k-1];
    endfunction

    task automatic model_clear();
        hist.delete();
        m_hex = '0; m_dp = '0; m_valid = '0; m_seen = '0; m_errc = '0;
    endtask

    // Edge t sees input t-1 as the registered sample; a capture happens when that
    // sample closes a run of exactly SC identical one-hot samples.
    task automatic model_step();
        int            t;
        logic [ND+7:0] v;
        logic          cap;
        exp_t          e;
        t   = hist.size();
        v   = hist_at(t - 1);
        cap = $onehot(v[ND+7:8]);
        for (int j = 1; j < SC; j++) begin
            if (hist_at(t - 1 - j) != v) cap = 1'b0;
        end
        if (hist_at(t - 1 - SC) == v) cap = 1'b0;
        e.frame = 1'b0;
        e.perr  = 1'b0;
        if (cap) begin
            int   d;
            int   g;
            logic blank;
            d = 0;
            for (int i = 0; i < ND; i++) if (v[8+i]) d = i;
            g = -1;
            for (int k = 0; k < 16; k++) if (glyph_tbl[k] == v[7:1]) g = k;
            blank = (v[7:1] == 7'd0);
            if (g >= 0) begin
                m_hex[4*d +: 4] = 4'(g);
                m_dp[d]    = v[0];
                m_valid[d] = 1'b1;
                m_seen[d]  = 1'b1;
            end else if (blank) begin
                m_dp[d]    = v[0];
                m_valid[d] = 1'b0;
                m_seen[d]  = 1'b1;
            end else begin
                m_valid[d] = 1'b0;
                e.perr     = 1'b1;
`ifdef SEG_CAPTURE_ERR_COUNT_EN
                if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
`endif
            end
            if ((g >= 0 || blank) && (&m_seen)) begin
                e.frame = 1'b1;
                m_seen  = '0;
            end
        end
        e.hex   = m_hex;
        e.dp    = m_dp;
        e.valid = m_valid;
        e.errc  = m_errc;
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    // Called at negedge+1; returns at the next negedge+1 after the monitor compared.
    task automatic drive_cycle(input logic [ND-1:0] sel, input logic [7:0] seg);
        dig_sel = sel;
        seg_in  = seg;
        hist.push_back({sel, seg});
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        check("rst_hex",   32'(hex_out),     32'h0);
        check("rst_dp",    32'(dp_out),      32'h0);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_frame", 32'(frame_done),  32'h0);
        check("rst_perr",  32'(pattern_err), 32'h0);
        check("rst_errc",  32'(err_count),   32'h0);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_seg();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return {glyph_tbl[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
        if (r < 8) return {7'd0, 1'($urandom_range(0, 1))};
        return 8'($urandom);
    endfunction

    function automatic logic [ND-1:0] rand_sel();
        int            r;
        logic [ND-1:0] s;
        r = int'($urandom_range(0, 19));
        if (r < 17) return ND'(1) << $urandom_range(0, ND - 1);
        if (r < 18) return '0;
        s = ND'($urandom);
        while ($onehot(s) || s == '0) s = ND'($urandom);
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  scan_seg[4];
        int          pulses;
        logic [7:0]  errc_req;

        glyph_tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        dig_sel  = '0;
        seg_in   = '0;
        @(negedge clk);
        #1;
        do_reset();

        // Single digit dwell: update lands on the fifth edge.
        for (int c = 1; c <= 8; c++) begin
            drive_cycle(4'b0001, 8'b11011010);
            if (c == 4) check("dwell_before_edge5", 32'(digit_valid), 32'h0);
            if (c == 5) begin
                check("dwell_hex_edge5",   32'(hex_out[3:0]), 32'h2);
                check("dwell_valid_edge5", 32'(digit_valid),  32'h1);
            end
        end
        check("dwell_dp", 32'(dp_out), 32'h0);

        // Full scan of four digits with blanking gaps.
        scan_seg = '{8'b11100001, 8'b01100000, 8'b10011100, 8'b11111110};
        pulses = 0;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 6; c++) begin
                drive_cycle(ND'(1) << d, scan_seg[d]);
                if (frame_done) pulses++;
            end
            drive_cycle('0, scan_seg[d]);
            if (frame_done) pulses++;
        end
        check("scan_hex",    32'(hex_out),     32'h8C17);
        check("scan_dp",     32'(dp_out),      32'h1);
        check("scan_valid",  32'(digit_valid), 32'hF);
        check("scan_frames", 32'(pulses),      32'd1);

        // Unknown pattern on digit 1.
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            drive_cycle(4'b0010, 8'b00001110);
            if (pattern_err) pulses++;
        end
`ifdef SEG_CAPTURE_ERR_COUNT_EN
        errc_req = 8'd1;
`else
        errc_req = 8'd0;
`endif
        check("perr_pulses", 32'(pulses),        32'd1);
        check("perr_valid1", 32'(digit_valid[1]), 32'h0);
        check("perr_hex1",   32'(hex_out[7:4]),   32'h1);
        check("perr_errc",   32'(err_count),      32'(errc_req));

        // Too-short dwells never capture.
        for (int c = 0; c < 18; c++)
            drive_cycle(4'b0001, ((c / 3) % 2 == 0) ? 8'b11110010 : 8'b10110110);
        check("toggle_hex",   32'(hex_out),     32'h8C17);
        check("toggle_valid", 32'(digit_valid), 32'hD);

        // Multi-hot select is blanking.
        for (int c = 0; c < 10; c++) drive_cycle(4'b0011, 8'b11111100);
        check("multihot_hex", 32'(hex_out), 32'h8C17);

        // Reset in the middle of a dwell, inputs held throughout.
        for (int c = 0; c < 3; c++) drive_cycle(4'b0100, 8'b10111110);
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            drive_cycle(4'b0100, 8'b10111110);
            if (c == 4) check("post_rst_edge4_valid", 32'(digit_valid), 32'h0);
        end
        check("post_rst_edge5_valid", 32'(digit_valid),   32'h4);
        check("post_rst_edge5_hex",   32'(hex_out[11:8]), 32'h6);

        // Randomized scanning with one reset partway through.
        for (int n = 0; n < 300; n++) begin
            logic [ND-1:0] s;
            logic [7:0]    g;
            int            len;
            s   = rand_sel();
            g   = rand_seg();
            len = int'($urandom_range(1, 8));
            for (int c = 0; c < len; c++) drive_cycle(s, g);
            for (int c = 0; c < int'($urandom_range(0, 2)); c++) drive_cycle('0, g);
            if (n == 150) do_reset();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
